// File: rtl/conv_vedge_filter.sv
// conv_vedge_filter
//  Streaming 3x3 vertical-edge filter for the grey-scale camera path.
//  Each output is |(B0 + 2*B1 + B2) - (T0 + 2*T1 + T2)| clipped to DW bits.
//  B is the current line and T is the line two above it. The window is
//  centred on (row-1, col-1) of the accepted pixel.
//
//  Ports
//   iCLK    in   1    system clock, rising edge
//   iRST    in   1    asynchronous active-low reset
//   iDATA   in   DW   input pixel, sampled when iDVAL=1
//   iDVAL   in   1    input pixel valid
//   oDATA   out  DW   filtered magnitude (holds while oDVAL=0)
//   oDVAL   out  1    one-cycle pulse per produced pixel
module conv_vedge_filter #(
   parameter int LINE_WIDTH = 640,
   parameter int DW         = 12
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic [DW-1:0] iDATA,
   input  logic          iDVAL,
   output logic [DW-1:0] oDATA,
   output logic          oDVAL
);

   localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam int SW = DW + 4;
   localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);

   // Line buffers are not reset. Validity gating keeps stale contents out of the output.
   logic [DW-1:0] lb0_mem [LINE_WIDTH];
   logic [DW-1:0] lb1_mem [LINE_WIDTH];
   logic [DW-1:0] lb0_rd;
   logic [DW-1:0] lb1_rd;

   logic [CW-1:0] col_q, col_d;
   logic [1:0]    row_q, row_d;
   // The middle window row has zero weight, so only the top and bottom rows are stored.
   logic [DW-1:0] t_q [3];
   logic [DW-1:0] t_d [3];
   logic [DW-1:0] b_q [3];
   logic [DW-1:0] b_d [3];
   logic          win_vld_q, win_vld_d;
   logic [DW-1:0] odata_q, odata_d;
   logic          odval_q, odval_d;

   logic [SW-1:0] top_w, bot_w, diff_w, mag_w;
   logic [DW-1:0] clip_w;

   assign lb0_rd = lb0_mem[col_q];
   assign lb1_rd = lb1_mem[col_q];

   always_ff @(posedge iCLK) begin
      if (iDVAL) begin
         lb0_mem[col_q] <= iDATA;
         lb1_mem[col_q] <= lb0_rd;
      end
   end

   always_comb begin
      col_d     = col_q;
      row_d     = row_q;
      t_d       = t_q;
      b_d       = b_q;
      win_vld_d = 1'b0;
      if (iDVAL) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q != 2'd2) row_d = row_q + 2'd1;
         end else begin
            col_d = col_q + 1'b1;
         end
         t_d[0] = t_q[1];
         t_d[1] = t_q[2];
         t_d[2] = lb1_rd;
         b_d[0] = b_q[1];
         b_d[1] = b_q[2];
         b_d[2] = iDATA;
         // Windows at col 0/1 straddle the previous line and are dropped.
         win_vld_d = (row_q == 2'd2) && (col_q >= COL_TWO);
      end
   end

   always_comb begin
      top_w  = SW'(t_q[0]) + (SW'(t_q[1]) << 1) + SW'(t_q[2]);
      bot_w  = SW'(b_q[0]) + (SW'(b_q[1]) << 1) + SW'(b_q[2]);
      diff_w = bot_w - top_w;
      mag_w  = diff_w[SW-1] ? (SW'(0) - diff_w) : diff_w;
      clip_w = (|mag_w[SW-1:DW]) ? {DW{1'b1}} : mag_w[DW-1:0];
      odata_d = win_vld_q ? clip_w : odata_q;
      odval_d = win_vld_q;
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         col_q     <= '0;
         row_q     <= '0;
         win_vld_q <= 1'b0;
         odata_q   <= '0;
         odval_q   <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            t_q[i] <= '0;
            b_q[i] <= '0;
         end
      end else begin
         col_q     <= col_d;
         row_q     <= row_d;
         t_q       <= t_d;
         b_q       <= b_d;
         win_vld_q <= win_vld_d;
         odata_q   <= odata_d;
         odval_q   <= odval_d;
      end
   end

   assign oDATA = odata_q;
   assign oDVAL = odval_q;

endmodule

// File: tb/tb_conv_vedge_filter.sv
// Directed bench for conv_vedge_filter with LINE_WIDTH=4.
module tb_conv_vedge_filter;

   logic        iCLK;
   logic        iRST;
   logic [11:0] iDATA;
   logic        iDVAL;
   logic [11:0] oDATA;
   logic        oDVAL;

   int n_cmp = 0;
   int n_bad = 0;
   int got_q[$];
   int exp_q[$];

   conv_vedge_filter #(.LINE_WIDTH(4), .DW(12)) dut (
      .iCLK  (iCLK),
      .iRST  (iRST),
      .iDATA (iDATA),
      .iDVAL (iDVAL),
      .oDATA (oDATA),
      .oDVAL (oDVAL)
   );

   initial iCLK = 1'b0;
   always #10 iCLK = ~iCLK;

   always @(negedge iCLK) if (oDVAL === 1'b1) got_q.push_back(int'(oDATA));

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge iCLK);
      iRST  = 1'b0;
      iDVAL = 1'b0;
      iDATA = '0;
      @(negedge iCLK);
      chk("rst_odval", int'(oDVAL), 0);
      chk("rst_odata", int'(oDATA), 0);
      @(negedge iCLK);
      iRST = 1'b1;
   endtask

   task automatic beat(input logic [11:0] p, input bit gaps);
      if (gaps) begin
         @(negedge iCLK);
         iDVAL = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge iCLK);
      end
      @(negedge iCLK);
      iDATA = p;
      iDVAL = 1'b1;
   endtask

   task automatic line(input logic [11:0] a, input logic [11:0] b,
                       input logic [11:0] c, input logic [11:0] d, input bit gaps);
      beat(a, gaps);
      beat(b, gaps);
      beat(c, gaps);
      beat(d, gaps);
   endtask

   task automatic flush_chk(input string tag);
      int n;
      @(negedge iCLK);
      iDVAL = 1'b0;
      repeat (4) @(negedge iCLK);
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk($sformatf("%s_val%0d", tag, i), got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      iRST  = 1'b0;
      iDVAL = 1'b0;
      iDATA = '0;
      #30;
      chk("init_odval", int'(oDVAL), 0);
      chk("init_odata", int'(oDATA), 0);
      #20;
      @(negedge iCLK);
      iRST = 1'b1;

      // Two lines of zeros never produce output.
      line(0, 0, 0, 0, 0);
      line(0, 0, 0, 0, 0);
      flush_chk("lines01");

      // Rising edge, line 3 over zero line 1, then a falling edge.
      line(10, 10, 10, 10, 0);
      exp_q.push_back(40); exp_q.push_back(40);
      line(10, 10, 10, 10, 0);
      exp_q.push_back(40); exp_q.push_back(40);
      line(0, 0, 0, 0, 0);
      exp_q.push_back(40); exp_q.push_back(40);
      flush_chk("edges");
      chk("hold_odata", int'(oDATA), 40);

      // A mid-stream reset clears the output and restarts the line count.
      do_reset();
      line(100, 100, 100, 100, 0);
      line(100, 100, 100, 100, 0);
      line(100, 100, 100, 100, 0);
      line(100, 100, 100, 100, 0);
      repeat (4) exp_q.push_back(0);
      flush_chk("flat");

      // Saturation, gapless and with gaps.
      for (int g = 0; g < 2; g++) begin
         do_reset();
         line(0, 0, 0, 0, g[0]);
         line(0, 0, 0, 0, g[0]);
         line(4095, 4095, 4095, 4095, g[0]);
         exp_q.push_back(4095); exp_q.push_back(4095);
         flush_chk(g ? "sat_gap" : "sat");
      end

      // Weighting checks: bottom 1,2,1 and then top 1,2,1. Run gapless and gapped.
      for (int g = 0; g < 2; g++) begin
         do_reset();
         line(0, 0, 0, 0, g[0]);
         line(0, 0, 0, 0, g[0]);
         line(1, 2, 3, 4, g[0]);
         exp_q.push_back(8); exp_q.push_back(12);
         line(5, 0, 7, 100, g[0]);
         exp_q.push_back(12); exp_q.push_back(114);
         line(0, 0, 0, 0, g[0]);
         exp_q.push_back(8); exp_q.push_back(12);
         flush_chk(g ? "wgt_gap" : "wgt");
      end
      chk("end_odval", int'(oDVAL), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
